frame_packer: RTL and testbench

Upstream stimulus/source stage for `frame_detector`. It accepts one payload descriptor per handshake: a one-hot channel, a payload of 1–8 words and a word count. It serialises the descriptor into the 16-bit big-endian framed stream that `frame_detector` consumes on `data_in`: header, channel word, payload words, CRC-16, trailer, idle gap. The CRC is computed on the fly with the same word-parallel CRC the detector checks.

---
 rtl/frame_pkg.sv | 38 +++
 rtl/crc16_w16.sv | 23 ++
 rtl/frame_packer.sv | 152 +++++++++++++++
 tb/tb_frame_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the framed 16-bit stream: markers, packer states and
// the word-parallel CRC-16 used by both sender and checker.
package frame_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CHAN_W = 8;
    localparam int unsigned PAY_W  = 128;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [31:0]       HEADER_DEFAULT  = 32'hE0E0E0E0;
    localparam logic [31:0]       TRAILER_DEFAULT = 32'h0E0E0E0E;
    localparam logic [WORD_W-1:0] CRC_POLY        = 16'h1021;

    typedef enum logic [3:0] {
        PK_IDLE = 4'd0,
        PK_HDR0 = 4'd1,
        PK_HDR1 = 4'd2,
        PK_CHAN = 4'd3,
        PK_DATA = 4'd4,
        PK_CRC  = 4'd5,
        PK_TRL0 = 4'd6,
        PK_TRL1 = 4'd7,
        PK_GAP  = 4'd8
    } pk_state_t;

    // x^16+x^12+x^5+1, one 16-bit word per call, word MSB first, no reflection
    function automatic logic [WORD_W-1:0] crc16_step(input logic [WORD_W-1:0] crc,
                                                     input logic [WORD_W-1:0] word);
        logic [WORD_W-1:0] c;
        c = crc;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            c = {c[WORD_W-2:0], 1'b0} ^ ((c[WORD_W-1] ^ word[i]) ? CRC_POLY : '0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_w16.sv
// CRC-16 accumulator advancing one full payload word per enabled cycle.
module crc16_w16
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc16_step(crc, word);
        end
    end

endmodule

// File: rtl/frame_packer.sv
// Serialises one payload descriptor into the framed stream:
// header, channel, payload words (MSW first), CRC-16, trailer, idle gap.
module frame_packer
    import frame_pkg::*;
#(
    parameter logic [31:0]       HEADER    = HEADER_DEFAULT,
    parameter logic [31:0]       TRAILER   = TRAILER_DEFAULT,
    parameter logic [WORD_W-1:0] IDLE_WORD = 16'h0000,
    parameter int unsigned       GAP_WORDS = 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [CHAN_W-1:0] channel,
    input  logic [PAY_W-1:0]  payload,
    input  logic [LEN_W-1:0]  len_words,
    output logic [WORD_W-1:0] data_out,
    output logic              data_out_vld,
    output logic              done,
    output logic              cfg_err
);

    pk_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        gap_cnt, gap_nxt;
    logic [CHAN_W-1:0] chan_q;
    logic [PAY_W-1:0]  pay_q;
    logic              load, reject, desc_ok;
    logic              crc_clr, crc_en;
    logic [WORD_W-1:0] crc_word, crc;
    logic [WORD_W-1:0] word_c;
    logic              vld_c;

    assign desc_ok  = $onehot(channel) && (len_words >= 4'd1) && (len_words <= 4'd8);
    assign crc_word = pay_q[{cnt, 4'b0000} +: WORD_W];

    crc16_w16 u_crc (
        .clk   (clk_in),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .word  (crc_word),
        .crc   (crc)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PK_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            chan_q  <= '0;
            pay_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            if (load) begin
                chan_q <= channel;
                pay_q  <= payload;
            end
        end
    end

    // Next state; the GAP state covers only GAP_WORDS-1 cycles because the
    // IDLE cycle that accepts the next descriptor supplies the last idle word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        load      = 1'b0;
        reject    = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        case (state)
            PK_IDLE: begin
                if (start && ready) begin
                    if (desc_ok) begin
                        state_nxt = PK_HDR0;
                        cnt_nxt   = CNT_W'(len_words - 4'd1);
                        load      = 1'b1;
                        crc_clr   = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PK_HDR0: state_nxt = PK_HDR1;
            PK_HDR1: state_nxt = PK_CHAN;
            PK_CHAN: state_nxt = PK_DATA;
            PK_DATA: begin
                crc_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = PK_CRC;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PK_CRC:  state_nxt = PK_TRL0;
            PK_TRL0: state_nxt = PK_TRL1;
            PK_TRL1: begin
                if (GAP_WORDS > 1) begin
                    state_nxt = PK_GAP;
                    gap_nxt   = 4'(GAP_WORDS - 2);
                end else begin
                    state_nxt = PK_IDLE;
                end
            end
            PK_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = PK_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = PK_IDLE;
        endcase
    end

    // Word selected by the current state, registered on the next edge
    always_comb begin
        word_c = IDLE_WORD;
        vld_c  = 1'b1;
        case (state)
            PK_HDR0: word_c = HEADER[31:16];
            PK_HDR1: word_c = HEADER[15:0];
            PK_CHAN: word_c = {8'h00, chan_q};
            PK_DATA: word_c = crc_word;
            PK_CRC:  word_c = crc;
            PK_TRL0: word_c = TRAILER[31:16];
            PK_TRL1: word_c = TRAILER[15:0];
            default: vld_c  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= IDLE_WORD;
            data_out_vld <= 1'b0;
            ready        <= 1'b1;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            data_out     <= word_c;
            data_out_vld <= vld_c;
            ready        <= (state_nxt == PK_IDLE);
            done         <= (state == PK_TRL1);
            cfg_err      <= reject;
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Self-checking bench for frame_packer: directed table, back-to-back,
// reset mid-frame and randomized descriptors against a stream model.
module tb_frame_packer;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   channel = '0;
    logic [127:0] payload = '0;
    logic [3:0]   len_words = '0;
    logic         ready, data_out_vld, done, cfg_err;
    logic [15:0]  data_out;

    int tests = 0;
    int fails = 0;

    typedef logic [16:0] sw_t;   // {vld, word}
    sw_t exp_q[$];

    typedef struct {
        logic [7:0]   ch;
        logic [127:0] pay;
        logic [3:0]   len;
        logic         exp_err;
        logic         crc_known;
        logic [15:0]  exp_crc;
    } vec_t;
    vec_t vecs[8];

    always #5 clk_in = ~clk_in;

    frame_packer #(.GAP_WORDS(1)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .start        (start),
        .ready        (ready),
        .channel      (channel),
        .payload      (payload),
        .len_words    (len_words),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // CRC as remainder of M(x)*x^16 divided by the generator, by long division
    function automatic logic [15:0] ref_crc(input logic [127:0] pay, input int len);
        logic [143:0] m;
        logic [127:0] msk;
        msk = (len >= 8) ? '1 : ((128'd1 << (16 * len)) - 128'd1);
        m = {pay & msk, 16'h0000};
        for (int i = 143; i >= 16; i--) begin
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
        end
        return m[15:0];
    endfunction

    task automatic push_frame(input logic [7:0] ch, input logic [127:0] pay, input int len);
        logic [127:0] sh;
        exp_q.push_back({1'b1, 16'hE0E0});
        exp_q.push_back({1'b1, 16'hE0E0});
        exp_q.push_back({1'b1, 8'h00, ch});
        for (int k = 0; k < len; k++) begin
            sh = pay >> (16 * (len - 1 - k));
            exp_q.push_back({1'b1, sh[15:0]});
        end
        exp_q.push_back({1'b1, ref_crc(pay, len)});
        exp_q.push_back({1'b1, 16'h0E0E});
        exp_q.push_back({1'b1, 16'h0E0E});
    endtask

    // Called at a negedge with the block idle; leaves it idle at a negedge
    task automatic send_frame(input logic [7:0] ch, input logic [127:0] pay, input logic [3:0] len,
                              input logic crc_known, input logic [15:0] exp_crc);
        int l;
        l = int'(len);
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h0000});
        push_frame(ch, pay, l);
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b0, 16'h0000});
        chk("ready_before", 32'(ready), 32'd1);
        channel = ch; payload = pay; len_words = len; start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_in);
            if (i == 0) begin
                start = 1'b0;
                channel = 8'($urandom);
                payload = {$urandom, $urandom, $urandom, $urandom};
                len_words = 4'($urandom);
                chk("ready_busy", 32'(ready), 32'd0);
            end
            if (i == 3) begin
                start = 1'b1; channel = 8'h80; len_words = 4'd2;
            end
            if (i == 4) start = 1'b0;
            chk("stream", 32'({data_out_vld, data_out}), 32'(exp_q[i]));
            chk("done", 32'(done), 32'(i == l + 6));
            chk("cfg_err_quiet", 32'(cfg_err), 32'd0);
            if (crc_known && i == l + 4) chk("crc_word", 32'(data_out), 32'(exp_crc));
        end
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    task automatic send_bad(input logic [7:0] ch, input logic [3:0] len);
        chk("rej_ready_before", 32'(ready), 32'd1);
        channel = ch; payload = 128'h1; len_words = len; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("rej_cfg_err", 32'(cfg_err), 32'd1);
        chk("rej_data", 32'({data_out_vld, data_out}), 32'd0);
        chk("rej_ready", 32'(ready), 32'd1);
        @(negedge clk_in);
        chk("rej_cfg_err_clear", 32'(cfg_err), 32'd0);
        chk("rej_vld", 32'(data_out_vld), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h01, 128'h0001, 4'd1, 1'b0, 1'b1, 16'h1021};
        vecs[1] = '{8'h02, 128'h0002_0000, 4'd2, 1'b0, 1'b1, 16'h6E60};
        vecs[2] = '{8'h10, 128'h0123456789ABCDEFFEDCBA9876543210, 4'd8, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{8'h03, 128'h0001, 4'd1, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{8'h01, 128'h0001, 4'd0, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{8'h01, 128'h0001, 4'd9, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{8'h00, 128'h0001, 4'd3, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{8'h80, 128'hDEAD_BEEF_0000_FFFF_1234, 4'd5, 1'b0, 1'b0, 16'h0000};

        // Reset values
        repeat (2) @(negedge clk_in);
        chk("rst_data", 32'(data_out), 32'h0000);
        chk("rst_vld", 32'(data_out_vld), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_err) send_bad(vecs[v].ch, vecs[v].len);
            else send_frame(vecs[v].ch, vecs[v].pay, vecs[v].len, vecs[v].crc_known, vecs[v].exp_crc);
        end

        // Back-to-back with start held high; second descriptor set after first accept
        begin
            logic [127:0] pa, pb;
            int per;
            pa = 128'hAAAA_5555_1357;
            pb = 128'h0F0F_F0F0;
            per = 6 + 3 + 1;
            exp_q.delete();
            exp_q.push_back({1'b0, 16'h0000});
            push_frame(8'h04, pa, 3);
            exp_q.push_back({1'b0, 16'h0000});
            push_frame(8'h20, pb, 2);
            exp_q.push_back({1'b0, 16'h0000});
            exp_q.push_back({1'b0, 16'h0000});
            channel = 8'h04; payload = pa; len_words = 4'd3; start = 1'b1;
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk_in);
                if (i == 0) begin
                    channel = 8'h20; payload = pb; len_words = 4'd2;
                end
                if (i == per) begin
                    start = 1'b0;
                    payload = {$urandom, $urandom, $urandom, $urandom};
                end
                chk("b2b_stream", 32'({data_out_vld, data_out}), 32'(exp_q[i]));
            end
        end

        // Reset in the middle of DATA
        channel = 8'h08; payload = {4{32'h1111_2222}}; len_words = 4'd8; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("pre_rst_vld", 32'(data_out_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h0000);
        chk("mid_rst_vld", 32'(data_out_vld), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        send_frame(8'h40, 128'h0001, 4'd1, 1'b1, 16'h1021);

        // Randomized descriptors, occasionally illegal
        for (int r = 0; r < 24; r++) begin
            logic [7:0]   ch;
            logic [127:0] pay;
            logic [3:0]   len;
            pay = {$urandom, $urandom, $urandom, $urandom};
            ch  = 8'(8'd1 << $urandom_range(0, 7));
            len = 4'($urandom_range(1, 8));
            case ($urandom_range(0, 5))
                0: send_bad(8'(8'h03 << $urandom_range(0, 6)), len);
                1: send_bad(ch, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)));
                default: send_frame(ch, pay, len, 1'b0, 16'h0000);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
